// File: rtl/abro_multi.sv
// abro_multi: N-input ABRO sequence detector.
// Waits until every event input has been seen (any order, or strict ascending
// index order when ORDERED=1), then raises o, parks in DONE until the
// restart r, and counts completed sequences in a wrapping counter.
// All outputs are driven straight from flops.
module abro_multi #(
  parameter int N       = 2,
  parameter int ORDERED = 0,
  parameter int PULSE   = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     ev,
  input  logic             r,
  output logic             o,
  output logic [N-1:0]     seen,
  output logic [1:0]       state,
  output logic             err,
  output logic [CNT_W-1:0] fire_cnt
);

  // Reject unsupported widths at elaboration time.
  if (N < 2 || N > 32) begin : g_bad_n
    $fatal(1, "abro_multi: N=%0d outside legal range 2..32", N);
  end

  typedef enum logic [1:0] {
    ST_WAIT = 2'b00,
    ST_FIRE = 2'b01,
    ST_DONE = 2'b10,
    ST_ERR  = 2'b11
  } state_e;

  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};

  state_e             state_q, state_d;
  logic [N-1:0]       seen_q, seen_d;
  logic               o_q, o_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [N-1:0]       seen_n;
  logic [N-1:0]       seen_inc;
  logic               is_thermo;

  // Candidate capture set and thermometer test (2^m - 1 has no bit in common
  // with itself plus one; all ones wraps to zero and also qualifies).
  always_comb begin
    seen_n    = seen_q | ev;
    seen_inc  = seen_n + N'(1);
    is_thermo = ((seen_n & seen_inc) == '0);
  end

  // Next-state and next-output logic; restart overrides every state.
  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    o_d     = o_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (r) begin
      state_d = ST_WAIT;
      seen_d  = '0;
      o_d     = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_WAIT: begin
          if ((ORDERED != 0) && !is_thermo) begin
            // Out-of-order arrival: freeze seen and latch the error.
            state_d = ST_ERR;
            err_d   = 1'b1;
            o_d     = 1'b0;
          end else if (seen_n == ALL_ONES) begin
            state_d = ST_FIRE;
            seen_d  = seen_n;
            o_d     = 1'b1;
            cnt_d   = cnt_q + CNT_W'(1);
          end else begin
            seen_d  = seen_n;
          end
        end
        ST_FIRE: begin
          state_d = ST_DONE;
          o_d     = (PULSE == 0);
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        ST_ERR: begin
          err_d   = 1'b1;
          o_d     = 1'b0;
        end
        default: begin
          state_d = ST_WAIT;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_WAIT;
      seen_q  <= '0;
      o_q     <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      o_q     <= o_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o        = o_q;
  assign seen     = seen_q;
  assign state    = state_q;
  assign err      = err_q;
  assign fire_cnt = cnt_q;

endmodule

// File: tb/tb_abro_multi.sv
// Directed bench for abro_multi: four parameterisations share clock and reset.
module tb_abro_multi;

  logic clk;
  logic reset;

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // u1: N=3 unordered, pulse output, 8-bit counter.
  logic [2:0] ev1, seen1;
  logic       r1, o1, err1;
  logic [1:0] st1;
  logic [7:0] cnt1;
  abro_multi #(.N(3), .ORDERED(0), .PULSE(1), .CNT_W(8)) u1 (
    .clk(clk), .reset(reset), .ev(ev1), .r(r1), .o(o1), .seen(seen1),
    .state(st1), .err(err1), .fire_cnt(cnt1));

  // u2: N=2 unordered, held output.
  logic [1:0] ev2, seen2;
  logic       r2, o2, err2;
  logic [1:0] st2;
  logic [7:0] cnt2;
  abro_multi #(.N(2), .ORDERED(0), .PULSE(0), .CNT_W(8)) u2 (
    .clk(clk), .reset(reset), .ev(ev2), .r(r2), .o(o2), .seen(seen2),
    .state(st2), .err(err2), .fire_cnt(cnt2));

  // u3: N=4 ordered, pulse output.
  logic [3:0] ev3, seen3;
  logic       r3, o3, err3;
  logic [1:0] st3;
  logic [7:0] cnt3;
  abro_multi #(.N(4), .ORDERED(1), .PULSE(1), .CNT_W(8)) u3 (
    .clk(clk), .reset(reset), .ev(ev3), .r(r3), .o(o3), .seen(seen3),
    .state(st3), .err(err3), .fire_cnt(cnt3));

  // u4: N=2 unordered, 2-bit counter for wrap checks.
  logic [1:0] ev4, seen4;
  logic       r4, o4, err4;
  logic [1:0] st4;
  logic [1:0] cnt4;
  abro_multi #(.N(2), .ORDERED(0), .PULSE(1), .CNT_W(2)) u4 (
    .clk(clk), .reset(reset), .ev(ev4), .r(r4), .o(o4), .seen(seen4),
    .state(st4), .err(err4), .fire_cnt(cnt4));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    ev1 = '0; ev2 = '0; ev3 = '0; ev4 = '0;
    r1 = 1'b0; r2 = 1'b0; r3 = 1'b0; r4 = 1'b0;
    #12;
    reset = 1'b1;
    #1;
    chk("rst_st1",   32'(st1),   0);
    chk("rst_seen1", 32'(seen1), 0);
    chk("rst_o1",    32'(o1),    0);
    chk("rst_cnt1",  32'(cnt1),  0);
    chk("rst_err3",  32'(err3),  0);

    // 1: unordered, pulse.
    ev1 = 3'b001; tick();
    chk("t1_seen_a", 32'(seen1), 32'b001);
    chk("t1_st_a",   32'(st1),   0);
    ev1 = 3'b100; tick();
    chk("t1_seen_b", 32'(seen1), 32'b101);
    chk("t1_o_b",    32'(o1),    0);
    ev1 = 3'b010; tick();
    chk("t1_seen_c", 32'(seen1), 32'b111);
    chk("t1_st_c",   32'(st1),   1);
    chk("t1_o_c",    32'(o1),    1);
    chk("t1_cnt_c",  32'(cnt1),  1);
    ev1 = 3'b000; tick();
    chk("t1_st_d",   32'(st1),   2);
    chk("t1_o_d",    32'(o1),    0);
    ev1 = 3'b111; tick();
    chk("t1_st_e",   32'(st1),   2);
    chk("t1_cnt_e",  32'(cnt1),  1);
    ev1 = 3'b000; r1 = 1'b1; tick();
    r1 = 1'b0;
    chk("t1_st_r",   32'(st1),   0);
    chk("t1_seen_r", 32'(seen1), 0);

    // 5: restart beats completing event.
    ev1 = 3'b011; tick();
    chk("t5_seen_a", 32'(seen1), 32'b011);
    ev1 = 3'b100; r1 = 1'b1; tick();
    ev1 = 3'b000; r1 = 1'b0;
    chk("t5_st",     32'(st1),   0);
    chk("t5_seen",   32'(seen1), 0);
    chk("t5_o",      32'(o1),    0);
    chk("t5_cnt",    32'(cnt1),  1);

    // 2: simultaneous events, held output.
    ev2 = 2'b11; tick();
    chk("t2_st_f",   32'(st2),   1);
    chk("t2_o_f",    32'(o2),    1);
    chk("t2_cnt_f",  32'(cnt2),  1);
    for (int i = 0; i < 10; i++) begin
      ev2 = 2'(i);
      tick();
      chk("t2_st_done", 32'(st2), 2);
      chk("t2_o_done",  32'(o2),  1);
    end
    chk("t2_cnt_hold", 32'(cnt2), 1);
    ev2 = 2'b00; r2 = 1'b1; tick();
    r2 = 1'b0;
    chk("t2_o_r",    32'(o2),    0);
    chk("t2_st_r",   32'(st2),   0);

    // 3: ordered accept, including a contiguous multi-bit step.
    ev3 = 4'b0001; tick();
    chk("t3_seen_a", 32'(seen3), 32'b0001);
    ev3 = 4'b0110; tick();
    chk("t3_seen_b", 32'(seen3), 32'b0111);
    chk("t3_err_b",  32'(err3),  0);
    ev3 = 4'b1000; tick();
    chk("t3_st_c",   32'(st3),   1);
    chk("t3_o_c",    32'(o3),    1);
    chk("t3_err_c",  32'(err3),  0);
    chk("t3_cnt_c",  32'(cnt3),  1);
    ev3 = 4'b0000; tick();
    chk("t3_st_d",   32'(st3),   2);
    r3 = 1'b1; tick();
    r3 = 1'b0;
    chk("t3_st_r",   32'(st3),   0);

    // 4: ordered violation; re-asserting a seen bit is harmless first.
    ev3 = 4'b0001; tick();
    ev3 = 4'b0001; tick();
    chk("t4_seen_a", 32'(seen3), 32'b0001);
    chk("t4_st_a",   32'(st3),   0);
    ev3 = 4'b0100; tick();
    chk("t4_st_b",   32'(st3),   3);
    chk("t4_err_b",  32'(err3),  1);
    chk("t4_seen_b", 32'(seen3), 32'b0001);
    chk("t4_o_b",    32'(o3),    0);
    ev3 = 4'b1111; tick();
    chk("t4_st_c",   32'(st3),   3);
    chk("t4_err_c",  32'(err3),  1);
    chk("t4_seen_c", 32'(seen3), 32'b0001);
    chk("t4_o_c",    32'(o3),    0);
    chk("t4_cnt_c",  32'(cnt3),  1);
    ev3 = 4'b0000; r3 = 1'b1; tick();
    r3 = 1'b0;
    chk("t4_st_r",   32'(st3),   0);
    chk("t4_err_r",  32'(err3),  0);
    chk("t4_seen_r", 32'(seen3), 0);

    // 6: counter wrap on a 2-bit counter.
    for (int k = 1; k <= 4; k++) begin
      ev4 = 2'b11; tick();
      chk("t6_cnt", 32'(cnt4), 32'(k % 4));
      ev4 = 2'b00; r4 = 1'b1; tick();
      r4 = 1'b0;
    end
    ev4 = 2'b01; tick();
    ev4 = 2'b00;
    chk("t6_seen_mid", 32'(seen4), 32'b01);

    // Asynchronous reset between edges clears everything at once.
    #2;
    reset = 1'b0;
    #1;
    chk("t6_ar_seen4", 32'(seen4), 0);
    chk("t6_ar_st4",   32'(st4),   0);
    chk("t6_ar_cnt1",  32'(cnt1),  0);
    chk("t6_ar_cnt2",  32'(cnt2),  0);
    chk("t6_ar_cnt3",  32'(cnt3),  0);
    chk("t6_ar_o2",    32'(o2),    0);
    #3;
    reset = 1'b1;
    tick();
    chk("t6_post_st4", 32'(st4), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/abro_multi.md
Name: abro_multi

Overview:
- Parametrised successor to the two-input ABRO controller.
- Waits for all N event inputs to have been seen, in any order or in strict index order depending on mode.
- Then emits O, holds in a done state until the restart input R, and counts completed sequences.
- Sits as the sequence-detection FSM between input conditioning and downstream control logic.

Parameters:
- N, 2, number of event inputs (legal 2..32).
- ORDERED, 0, 0 = events accepted in any order; 1 = events must arrive in ascending index order.
- PULSE, 1, 1 = O is a one-cycle pulse; 0 = O is held high until restart.
- CNT_W, 8, width of the completion counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- ev  input  N  event levels, sampled every rising edge.
- r  input  1  synchronous restart.
- o  output  1  sequence-complete output, registered.
- seen  output  N  events captured so far, registered.
- state  output  2  FSM state: 00 WAIT, 01 FIRE, 10 DONE, 11 ERR.
- err  output  1  ordering violation flag (ORDERED=1 only), registered.
- fire_cnt  output  CNT_W  number of completed sequences, wraps.

Behaviour:
- Reset (reset=0, asynchronous): state=WAIT, seen=0, o=0, err=0, fire_cnt=0. Outputs are released on the first rising edge after reset returns high.
- All outputs come straight from flops; no combinational path from input to output.
- r has priority in every state. At an edge with r=1: state=WAIT, seen=0, o=0, err=0. ev in that cycle is discarded. fire_cnt is not cleared by r.
- WAIT, ORDERED=0: seen_n = seen | ev.
  - If seen_n is all ones: state->FIRE, o=1, fire_cnt+1, and seen is updated. Latency is one edge from sampling the last event to o=1.
  - Otherwise: seen <= seen_n.
- WAIT, ORDERED=1: seen_n = seen | ev. seen_n must be a thermometer code (2^m - 1).
  - Thermometer and all ones: FIRE, as in the unordered case.
  - Thermometer, not all ones: seen <= seen_n.
  - Not thermometer: state->ERR, err=1, seen unchanged, o=0.
- Consequences of the ORDERED=1 rule:
  - A contiguous run of new events starting at the next expected index is accepted in one cycle.
  - Re-assertion of already-seen bits is harmless.
- FIRE: lasts exactly one cycle, then DONE.
  - PULSE=1: o=0 in DONE.
  - PULSE=0: o stays 1 in DONE.
  - ev is ignored in FIRE.
- DONE: ev is ignored. Remains in DONE until r=1, which returns to WAIT.
- ERR: err=1 and o=0 are held, ev is ignored, until r=1.
- ERR is unreachable when ORDERED=0.
- Simultaneous completion: all N bits arriving in the same cycle from seen=0 fires in that cycle. In ordered mode this is legal because all ones is a thermometer code.
- r=1 together with completing ev: r wins, no FIRE, and fire_cnt is unchanged.
- fire_cnt wraps from 2^CNT_W-1 to 0.
- Asynchronous reset mid-sequence: all state is lost immediately, including fire_cnt.
- Elaboration: N outside 2..32 is a fatal error.

Test Plan:
1. Unordered and pulse mode (N=3, ORDERED=0, PULSE=1): from reset, ev=001, then 100, then 010 on successive edges.
   - seen goes 001 -> 101 -> 111.
   - o=1 for exactly one cycle after the third edge, state 01 -> 10, fire_cnt=1.
   - r=1 for one cycle -> state=00, seen=000.
2. Simultaneous events and held output (N=2, PULSE=0): ev=11 in one cycle.
   - FIRE next edge, then DONE with o held at 1 for 10 cycles while ev toggles.
   - r=1 drops o to 0 and state to 00.
3. Ordered accept (N=4, ORDERED=1): ev=0001, then 0110, then 1000.
   - seen goes 0001 -> 0111 -> FIRE.
   - err stays 0, fire_cnt=1.
4. Ordered violation (N=4, ORDERED=1): ev=0001, then 0100.
   - state=11, err=1, seen=0001, o=0.
   - Further ev=1111 gives no change.
   - r=1 -> WAIT, err=0.
5. Restart priority (N=3, ORDERED=0): seen=011; at one edge apply ev=100 and r=1 together.
   - Result: state=00, seen=000, o=0, fire_cnt unchanged.
6. Asynchronous reset and counter wrap (CNT_W=2):
   - Complete 4 sequences -> fire_cnt goes 1, 2, 3, 0.
   - Drop reset mid-WAIT, between clock edges -> all outputs 0 immediately, before the next clk edge.
